meas_avg: RTL

Measurement averaging stage placed between the measure block's result output and the regfile write port. It accumulates 2^n consecutive 64-bit results, each packed as {ref_cnt[31:0], sig_cnt[31:0]}, then writes back one averaged result. This averaging reduces ±1-count gating jitter without changing the regfile's write interface. It takes no back-pressure and never drops an accepted sample.

---
 rtl/meas_avg_pkg.sv | 31 +++
 rtl/meas_acc.sv | 64 ++++++
 rtl/meas_avg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/meas_avg_pkg.sv
// Shared definitions for the measurement averaging stage: default widths,
// the packed {ref, sig} result word, window state encoding and the clamp
// applied to the requested window length.
package meas_avg_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_AVG_LOG2_MAX = 4;
  localparam int ACC_WIDTH        = DEF_DATA_WIDTH + DEF_AVG_LOG2_MAX;

  // One measure result as it arrives from the measure block.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] ref_cnt;
    logic [DEF_DATA_WIDTH-1:0] sig_cnt;
  } meas_word_t;

  // Window occupancy; the close event returns the window to WIN_EMPTY.
  typedef enum logic [0:0] {
    WIN_EMPTY = 1'b0,
    WIN_FILL  = 1'b1
  } win_state_t;

  // Requested log2 window length limited to what the accumulators can hold
  // without wrapping.
  function automatic logic [2:0] clamp_log2(input logic [2:0] req, input int max_log2);
    if (int'(req) > max_log2) begin
      return 3'(max_log2);
    end
    return req;
  endfunction

endpackage

// File: rtl/meas_acc.sv
// One field of the averager: running accumulator, stage-1 window sum and
// stage-2 truncating divide-by-2^n. Control comes entirely from meas_avg.
module meas_acc
  import meas_avg_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int AVG_LOG2_MAX = DEF_AVG_LOG2_MAX
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,     // flush the partial sum
  input  logic                  add_i,     // accepted sample this cycle
  input  logic                  close_i,   // accepted sample completes the window
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  ld_out_i,  // stage-1 sum is valid, produce average
  input  logic [2:0]            shift_i,   // n latched for the closed window
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;

  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      s1_q, s1_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [ACC_W-1:0]      sum;

  // Next-state for accumulator, stage-1 sum and stage-2 average.
  always_comb begin
    sum   = acc_q + {{AVG_LOG2_MAX{1'b0}}, sample_i};
    acc_d = acc_q;
    s1_d  = s1_q;
    out_d = out_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (close_i) begin
      // The closing sample goes straight into the window sum so the
      // accumulator is free for a new window on the very next cycle.
      acc_d = '0;
      s1_d  = sum;
    end else if (add_i) begin
      acc_d = sum;
    end
    if (ld_out_i) begin
      // Truncating shift; the average of DATA_WIDTH-bit samples always fits.
      out_d = DATA_WIDTH'(s1_q >> shift_i);
    end
  end

  // Field registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      s1_q  <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      s1_q  <= s1_d;
      out_q <= out_d;
    end
  end

  assign data_o = out_q;

endmodule

// File: rtl/meas_avg.sv
// Measurement averaging stage between the measure block and the regfile
// write port. Averages 2^n consecutive {ref, sig} results and emits one
// write strobe two cycles after the window's last sample.
module meas_avg
  import meas_avg_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int AVG_LOG2_MAX = DEF_AVG_LOG2_MAX
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2:0]              avg_log2_i,
  input  logic                    clr_i,
  input  logic                    in_vld_i,
  input  logic [2*DATA_WIDTH-1:0] in_data_i,
  output logic                    out_vld_o,
  output logic [2*DATA_WIDTH-1:0] out_data_o,
  output logic                    busy_o,
  output logic [AVG_LOG2_MAX:0]   win_cnt_o
);

  localparam int CW = AVG_LOG2_MAX + 1;

  win_state_t    state_q, state_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [2:0]    n_q, n_d;     // n of the window being filled
  logic [2:0]    n1_q, n1_d;   // n of the window sitting in stage 1
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;

  logic          accept;
  logic          win_start;
  logic          win_busy;
  logic [2:0]    n_eff;
  logic          close;
  logic          ld_out;

  // Sample acceptance, effective n and window-close detection.
  always_comb begin
    accept = in_vld_i & ~clr_i;
    n_eff  = win_start ? clamp_log2(avg_log2_i, AVG_LOG2_MAX) : n_q;
    close  = accept & ((win_cnt_q + CW'(1)) == (CW'(1) << n_eff));
    ld_out = v1_q & ~clr_i;
  end

  // Window state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WIN_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Window next-state: a one-sample window (n = 0) closes without leaving EMPTY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WIN_EMPTY: if (accept && !close) state_d = WIN_FILL;
      WIN_FILL:  if (clr_i || close)   state_d = WIN_EMPTY;
      default:                         state_d = WIN_EMPTY;
    endcase
  end

  // Window state decode.
  always_comb begin
    win_start = (state_q == WIN_EMPTY);
    win_busy  = (state_q == WIN_FILL);
  end

  // Counter, n latches and the two-stage valid pipeline.
  always_comb begin
    win_cnt_d = win_cnt_q;
    n_d       = n_q;
    n1_d      = n1_q;
    if (clr_i || close) begin
      win_cnt_d = '0;
    end else if (accept) begin
      win_cnt_d = win_cnt_q + CW'(1);
    end
    if (accept && win_start) begin
      n_d = n_eff;
    end
    if (close) begin
      n1_d = n_eff;
    end
    v1_d = close;
    v2_d = ld_out;
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_cnt_q <= '0;
      n_q       <= '0;
      n1_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      n_q       <= n_d;
      n1_q      <= n1_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
    end
  end

  logic [DATA_WIDTH-1:0] ref_avg;
  logic [DATA_WIDTH-1:0] sig_avg;

  meas_acc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .AVG_LOG2_MAX(AVG_LOG2_MAX)
  ) u_acc_ref (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .add_i   (accept),
    .close_i (close),
    .sample_i(in_data_i[2*DATA_WIDTH-1:DATA_WIDTH]),
    .ld_out_i(ld_out),
    .shift_i (n1_q),
    .data_o  (ref_avg)
  );

  meas_acc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .AVG_LOG2_MAX(AVG_LOG2_MAX)
  ) u_acc_sig (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .add_i   (accept),
    .close_i (close),
    .sample_i(in_data_i[DATA_WIDTH-1:0]),
    .ld_out_i(ld_out),
    .shift_i (n1_q),
    .data_o  (sig_avg)
  );

  assign out_vld_o  = v2_q;
  assign out_data_o = {ref_avg, sig_avg};
  assign busy_o     = win_busy;
  assign win_cnt_o  = win_cnt_q;

endmodule
